sprite_palette_bank: RTL and testbench
======================================

Name: sprite_palette_bank

Overview:
Programmable, multi-bank sprite colour palette with a global fade engine. It converts a per-pixel palette index from a sprite ROM into 4-bit-per-channel RGB for the VGA colour mapper. Each bank holds one palette; software writes entries at run time. The block has a 2-cycle read pipeline, a transparency flag and a timed brightness fade used for sprite fade-in and fade-out.

Parameters:
IDX_W, 4, palette index width; each bank has 2**IDX_W entries.
BANKS, 4, number of palette banks (power of 2, at least 2); BANK_W = $clog2(BANKS).
CH_W, 4, bits per colour channel.
TRANSP_IDX, 0, index that is treated as transparent in every bank.
FADE_DIV, 1024, clock cycles per fade step (at least 1).

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
wr_en  in  1  write strobe for palette memory
wr_bank  in  BANK_W  bank to write
wr_idx  in  IDX_W  entry to write
wr_rgb  in  3*CH_W  write data, packed {r,g,b}
rd_valid  in  1  pixel lookup request this cycle
rd_bank  in  BANK_W  bank selected by the sprite
rd_idx  in  IDX_W  pixel palette index
fade_start  in  1  one-cycle pulse that loads a new fade target
fade_target  in  CH_W+1  target brightness, 0 to 2**CH_W; values above 2**CH_W are clamped
red, green, blue  out  CH_W each  scaled colour
transparent  out  1  pixel is transparent
out_valid  out  1  outputs correspond to an accepted request
fade_busy  out  1  brightness level is not equal to the target

Behaviour:
- Storage: BANKS * 2**IDX_W entries, each 3*CH_W bits, held in registers.
  - Reset clears every entry to 0.
  - Reset sets level = target = 2**CH_W (full brightness) and clears the fade divider.
- Reset output values: red, green, blue, transparent, out_valid and fade_busy are all 0. The pipeline valid bits are cleared.
- Write: when wr_en=1, the entry [wr_bank][wr_idx] is updated at the clock edge. Writes are accepted every cycle and need no handshake.
- Read pipeline:
  - Stage 1 (edge N): if rd_valid=1, register the entry data, the transparency flag (rd_idx==TRANSP_IDX) and valid.
  - Stage 2 (edge N+1): each channel is computed as (c*level)>>CH_W, using a full-width product of 2*CH_W+1 bits with no rounding. This stage registers the outputs.
  - Latency: a request at cycle N produces outputs valid after edge N+1. Throughput is 1 lookup per cycle.
  - If rd_valid=0, out_valid drops 2 cycles later. When out_valid=0, the colour outputs hold their previous values.
- Transparent pixel: transparent=1 and red=green=blue=0, whatever the stored entry contains.
- Read/write collision on the same entry in the same cycle: the read returns the OLD data (read-before-write). The new data is visible to requests on the next cycle.
- Level sampling: stage 2 uses the level value at the time the pixel is in stage 2.
- Fade FSM, two states:
  - IDLE: level==target, fade_busy=0, divider held at 0. fade_start loads target (clamped). If the new target differs from level, go to FADING and clear the divider.
  - FADING: fade_busy=1. The divider counts 0 to FADE_DIV-1. On terminal count, level moves one step toward target and the divider wraps to 0. When level reaches target, return to IDLE.
  - fade_start during FADING: load the new target and restart the divider at 0. If the new target equals the current level, go to IDLE on the next edge.
  - Level saturates within 0 to 2**CH_W and never wraps.
- Reset asserted mid-fade or mid-pipeline overrides everything on that edge. In-flight lookups are discarded, with out_valid=0 on the next cycle.

Test Plan:
1. Reset, then write bank1 idx5 = 12'hC66, then rd_valid with bank1 idx5 at cycle N -> at cycle N+2: out_valid=1, {r,g,b}={C,6,6}, transparent=0.
2. Write bank2 idx0 = 12'hFFF, then read bank2 idx0 -> transparent=1, rgb=000. Read bank0 idx3 right after reset -> rgb=000, transparent=0.
3. Same-cycle write of 12'hABC and read of bank3 idx7 (old value 12'h123) -> output 123. Next-cycle read -> ABC.
4. Entry 12'hF84, fade_start with target 8, FADE_DIV=4 -> fade_busy for 32 cycles, level steps 16 to 8, final output {7,4,2}. Target 0 -> output 000 after 64 more cycles; fade_busy then clears.
5. fade_start target 0 during fade, then target 20 -> clamped to 16. Level reverses direction and the divider restarts; fade_busy stays 1 until level==16.
6. Back-to-back reads of 4 distinct entries, with Reset pulsed at the 3rd -> the first result appears, then out_valid=0 the cycle after Reset, and all outputs are 0.

Source files
------------

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: multi-bank RGB palette with a 2-stage lookup pipeline,
// transparency flag and a timed global brightness fade.
module sprite_palette_bank #(
  parameter int IDX_W = 4,
  parameter int BANKS = 4,
  parameter int CH_W = 4,
  parameter int TRANSP_IDX = 0,
  parameter int FADE_DIV = 1024,
  localparam int BANK_W = $clog2(BANKS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              rd_valid,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              fade_start,
  input  logic [CH_W:0]     fade_target,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              transparent,
  output logic              out_valid,
  output logic              fade_busy
);
  localparam int DEPTH = BANKS * (2 ** IDX_W);
  localparam int LVL_W = CH_W + 1;
  localparam int P_W = 2 * CH_W + 1;
  localparam int DIV_W = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(2 ** CH_W);
  typedef enum logic {IDLE, FADING} state_t;
  logic [3*CH_W-1:0] mem [DEPTH];
  logic [3*CH_W-1:0] s1_rgb;
  logic s1_transp, s1_valid;
  logic [P_W-1:0] pr, pg, pb;
  logic [LVL_W-1:0] level, level_n, target, target_n, clamp;
  logic [DIV_W-1:0] div, div_n;
  state_t state, state_n;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      s1_valid <= 1'b0;
      s1_transp <= 1'b0;
      s1_rgb <= '0;
    end else begin
      // read uses the pre-write contents, giving read-before-write on collisions
      s1_valid <= rd_valid;
      if (rd_valid) begin
        s1_rgb <= mem[{rd_bank, rd_idx}];
        s1_transp <= rd_idx == IDX_W'(TRANSP_IDX);
      end
      if (wr_en) mem[{wr_bank, wr_idx}] <= wr_rgb;
    end
  end
  assign pr = P_W'(s1_rgb[3*CH_W-1 -: CH_W]) * P_W'(level);
  assign pg = P_W'(s1_rgb[2*CH_W-1 -: CH_W]) * P_W'(level);
  assign pb = P_W'(s1_rgb[CH_W-1:0]) * P_W'(level);
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {red, green, blue, transparent, out_valid} <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        transparent <= s1_transp;
        red <= s1_transp ? '0 : CH_W'(pr >> CH_W);
        green <= s1_transp ? '0 : CH_W'(pg >> CH_W);
        blue <= s1_transp ? '0 : CH_W'(pb >> CH_W);
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      level <= FULL;
      target <= FULL;
      div <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      target <= target_n;
      div <= div_n;
    end
  end
  assign clamp = fade_target > FULL ? FULL : fade_target;
  always_comb begin
    state_n = state;
    level_n = level;
    target_n = target;
    div_n = '0;
    if (fade_start) begin
      target_n = clamp;
      state_n = clamp == level ? IDLE : FADING;
    end else if (state == FADING) begin
      if (div == DIV_W'(FADE_DIV - 1)) begin
        level_n = level < target ? level + LVL_W'(1) : level - LVL_W'(1);
        state_n = level_n == target ? IDLE : FADING;
      end else begin
        div_n = div + DIV_W'(1);
      end
    end
  end
  assign fade_busy = state == FADING;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: directed plan scenarios plus random traffic checked
// against a cycle-level behavioural model of palette, pipeline and fade.
module tb_sprite_palette_bank;
  localparam int FD = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic wr_en = 0, rd_valid = 0, fade_start = 0;
  logic [1:0] wr_bank = 0, rd_bank = 0;
  logic [3:0] wr_idx = 0, rd_idx = 0;
  logic [11:0] wr_rgb = 0;
  logic [4:0] fade_target = 0;
  logic [3:0] red, green, blue;
  logic transparent, out_valid, fade_busy;
  int n_tests = 0, n_fail = 0;
  logic [11:0] m_mem [4][16];
  int lvl, tgt, cnt, s1c, orr, og, ob;
  bit s1v, s1t, ov, ot;

  sprite_palette_bank #(.FADE_DIV(FD)) dut (
    .Clk(clk), .Reset(rst), .wr_en(wr_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
    .wr_rgb(wr_rgb), .rd_valid(rd_valid), .rd_bank(rd_bank), .rd_idx(rd_idx),
    .fade_start(fade_start), .fade_target(fade_target), .red(red), .green(green),
    .blue(blue), .transparent(transparent), .out_valid(out_valid), .fade_busy(fade_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scale(input int c);
    return (c * lvl) / 16;
  endfunction

  task automatic model_edge();
    if (rst) begin
      foreach (m_mem[b, i]) m_mem[b][i] = 0;
      lvl = 16; tgt = 16; cnt = 0;
      s1v = 0; ov = 0; ot = 0; orr = 0; og = 0; ob = 0;
      return;
    end
    if (s1v) begin
      ot = s1t;
      orr = s1t ? 0 : scale((s1c >> 8) & 15);
      og = s1t ? 0 : scale((s1c >> 4) & 15);
      ob = s1t ? 0 : scale(s1c & 15);
    end
    ov = s1v;
    s1v = rd_valid;
    if (rd_valid) begin
      s1c = int'(m_mem[rd_bank][rd_idx]);
      s1t = rd_idx == 0;
    end
    if (wr_en) m_mem[wr_bank][wr_idx] = wr_rgb;
    if (fade_start) begin
      tgt = fade_target > 16 ? 16 : int'(fade_target);
      cnt = 0;
    end else if (lvl != tgt) begin
      cnt++;
      if (cnt == FD) begin
        cnt = 0;
        lvl += lvl < tgt ? 1 : -1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("out_valid", int'(out_valid), int'(ov));
    check("fade_busy", int'(fade_busy), int'(lvl != tgt));
    check("transparent", int'(transparent), int'(ot));
    check("rgb", int'({red, green, blue}), (orr << 8) | (og << 4) | ob);
  endtask

  task automatic write_px(input int b, input int i, input int v);
    wr_en = 1; wr_bank = 2'(b); wr_idx = 4'(i); wr_rgb = 12'(v);
    step();
    wr_en = 0;
  endtask

  task automatic read_px(input int b, input int i);
    rd_valid = 1; rd_bank = 2'(b); rd_idx = 4'(i);
    step();
    rd_valid = 0;
    step();
  endtask

  initial begin
    int n;
    rst = 1;
    step();
    step();
    rst = 0;
    check("reset_valid", int'(out_valid), 0);
    check("reset_busy", int'(fade_busy), 0);
    write_px(1, 5, 'hC66);
    read_px(1, 5);
    check("t1_rgb", int'({red, green, blue}), 'hC66);
    write_px(2, 0, 'hFFF);
    read_px(2, 0);
    check("t2_transp", int'(transparent), 1);
    check("t2_rgb", int'({red, green, blue}), 0);
    read_px(0, 3);
    check("t2_empty", int'({red, green, blue, transparent}), 0);
    write_px(3, 7, 'h123);
    wr_en = 1; wr_bank = 3; wr_idx = 7; wr_rgb = 'hABC;
    rd_valid = 1; rd_bank = 3; rd_idx = 7;
    step();
    wr_en = 0;
    rd_valid = 1;
    step();
    rd_valid = 0;
    check("t3_old", int'({red, green, blue}), 'h123);
    step();
    check("t3_new", int'({red, green, blue}), 'hABC);
    write_px(0, 1, 'hF84);
    fade_start = 1; fade_target = 8;
    step();
    fade_start = 0;
    n = 0;
    while (fade_busy && n < 200) begin
      n++;
      step();
    end
    check("t4_busy_cycles", n, 32);
    read_px(0, 1);
    check("t4_rgb", int'({red, green, blue}), 'h742);
    fade_start = 1; fade_target = 0;
    step();
    fade_start = 0;
    repeat (64) step();
    check("t4_busy_clear", int'(fade_busy), 0);
    read_px(0, 1);
    check("t4_black", int'({red, green, blue}), 0);
    fade_start = 1; fade_target = 0;
    step();
    fade_target = 20;
    repeat (6) step();
    fade_start = 0;
    repeat (5) step();
    fade_start = 1;
    step();
    fade_start = 0;
    n = 0;
    while (fade_busy && n < 200) begin
      n++;
      step();
    end
    check("t5_level_full", lvl, 16);
    check("t5_idle", int'(fade_busy), 0);
    write_px(0, 2, 'h111);
    write_px(0, 4, 'h222);
    write_px(1, 6, 'h333);
    write_px(2, 8, 'h444);
    rd_valid = 1; rd_bank = 0; rd_idx = 2;
    step();
    rd_bank = 0; rd_idx = 4;
    step();
    check("t6_first", int'({red, green, blue}), 'h111);
    rd_bank = 1; rd_idx = 6; rst = 1;
    step();
    rst = 0;
    rd_bank = 2; rd_idx = 8;
    step();
    rd_valid = 0;
    check("t6_flush", int'({out_valid, red, green, blue, transparent}), 0);
    step();
    for (int k = 0; k < 3000; k++) begin
      wr_en = 1'($urandom);
      wr_bank = 2'($urandom); wr_idx = 4'($urandom); wr_rgb = 12'($urandom);
      rd_valid = $urandom_range(0, 3) != 0;
      rd_bank = 2'($urandom); rd_idx = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      fade_start = $urandom_range(0, 49) == 0;
      fade_target = 5'($urandom);
      rst = $urandom_range(0, 499) == 0;
      step();
    end
    rst = 0; wr_en = 0; rd_valid = 0; fade_start = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
